// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: strips E0/F0/E1 prefixes, tracks modifiers and Caps Lock,
// and queues completed key events in a show-ahead FIFO.
module ps2_key_decoder #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_stb_i,
    input  logic [7:0] scan_code_i,
    input  logic       rd_stb_i,
    input  logic       clr_ovf_i,
    output logic [9:0] event_o,
    output logic       valid_o,
    output logic       overflow_o,
    output logic [3:0] mod_o
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodePause = 8'hE1;
    localparam logic [7:0] CodeLShft = 8'h12;
    localparam logic [7:0] CodeRShft = 8'h59;
    localparam logic [7:0] CodeCtrl  = 8'h14;
    localparam logic [7:0] CodeAlt   = 8'h11;
    localparam logic [7:0] CodeCaps  = 8'h58;
    localparam logic [7:0] CodePKey  = 8'h77;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StPause
    } state_e;

    // Keyboard status/response bytes that never form part of a key event.
    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == CodeLShft) || (b == CodeRShft);
    endfunction

    state_e state_q, state_d;
    logic [2:0] skip_q, skip_d;

    logic       push;
    logic       push_ext;
    logic       push_brk;
    logic [7:0] push_code;

    logic lshift_q, lshift_d;
    logic rshift_q, rshift_d;
    logic lctrl_q, lctrl_d;
    logic rctrl_q, rctrl_d;
    logic lalt_q, lalt_d;
    logic ralt_q, ralt_d;
    logic caps_lock_q, caps_lock_d;
    logic caps_down_q, caps_down_d;

    logic [9:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               do_pop;
    logic               do_write;
    logic               ovf_set;

    // Prefix-stripping state machine; only advances on a received byte.
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        push      = 1'b0;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        push_code = scan_code_i;
        if (rx_stb_i) begin
            unique case (state_q)
                StIdle: begin
                    if (scan_code_i == CodeExt) begin
                        state_d = StExt;
                    end else if (scan_code_i == CodeBrk) begin
                        state_d = StBrk;
                    end else if (scan_code_i == CodePause) begin
                        state_d = StPause;
                        skip_d  = 3'd7;
                    end else if (!is_status(scan_code_i)) begin
                        push = 1'b1;
                    end
                end
                StExt: begin
                    if (scan_code_i == CodeBrk) begin
                        state_d = StExtBrk;
                    end else begin
                        state_d  = StIdle;
                        push     = !is_fake_shift(scan_code_i);
                        push_ext = 1'b1;
                    end
                end
                StBrk: begin
                    state_d  = StIdle;
                    push     = 1'b1;
                    push_brk = 1'b1;
                end
                StExtBrk: begin
                    state_d  = StIdle;
                    push     = !is_fake_shift(scan_code_i);
                    push_ext = 1'b1;
                    push_brk = 1'b1;
                end
                StPause: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d   = StIdle;
                        push      = 1'b1;
                        push_ext  = 1'b1;
                        push_code = CodePKey;
                    end
                end
                default: begin
                    state_d = StIdle;
                    skip_d  = '0;
                end
            endcase
        end
    end

    // Modifiers follow every decoded event, even one the FIFO has to drop.
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        lalt_d      = lalt_q;
        ralt_d      = ralt_q;
        caps_lock_d = caps_lock_q;
        caps_down_d = caps_down_q;
        if (push) begin
            if (!push_ext && push_code == CodeLShft) lshift_d = !push_brk;
            if (!push_ext && push_code == CodeRShft) rshift_d = !push_brk;
            if (push_code == CodeCtrl) begin
                if (push_ext) rctrl_d = !push_brk;
                else          lctrl_d = !push_brk;
            end
            if (push_code == CodeAlt) begin
                if (push_ext) ralt_d = !push_brk;
                else          lalt_d = !push_brk;
            end
            if (!push_ext && push_code == CodeCaps) begin
                if (push_brk) begin
                    caps_down_d = 1'b0;
                end else begin
                    // Typematic repeats arrive with caps_down already set.
                    if (!caps_down_q) caps_lock_d = !caps_lock_q;
                    caps_down_d = 1'b1;
                end
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        do_pop   = rd_stb_i && (count_q != '0);
        do_write = push && ((count_q != DepthCnt) || do_pop);
        ovf_set  = push && !do_write;
        wr_ptr_d = do_write ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q + (FIFO_AW + 1)'(do_write) - (FIFO_AW + 1)'(do_pop);
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            skip_q      <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_lock_q <= 1'b0;
            caps_down_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            lalt_q      <= lalt_d;
            ralt_q      <= ralt_d;
            caps_lock_q <= caps_lock_d;
            caps_down_q <= caps_down_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: a slot is only visible once count covers it.
    always_ff @(posedge clk_i) begin
        if (do_write) mem_q[wr_ptr_q] <= {push_ext, push_brk, push_code};
    end

    assign valid_o    = (count_q != '0);
    assign event_o    = valid_o ? mem_q[rd_ptr_q] : '0;
    assign overflow_o = ovf_q;
    assign mod_o      = {caps_lock_q, lalt_q | ralt_q, lctrl_q | rctrl_q, lshift_q | rshift_q};

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the PS/2 receiver's one-cycle scan-code strobe and assembles raw Set-2 bytes into complete key events. It strips the E0, F0 and E1 prefixes, discards keyboard status bytes, and tracks modifier and Caps Lock state. Completed events are queued in a show-ahead FIFO that the KeyboardController register interface pops for the 65C02.

## Interface
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW events
- clk_i  in  1  system clock (same domain as the receiver)
- rst_n_i  in  1  asynchronous, active-low reset
- rx_stb_i  in  1  one-cycle strobe: scan_code_i valid
- scan_code_i  in  8  received byte
- rd_stb_i  in  1  one-cycle pop of the FIFO head
- clr_ovf_i  in  1  clears overflow_o
- event_o  out  10  FIFO head {ext, brk, code[7:0]}; all-zero when empty
- valid_o  out  1  FIFO not empty
- overflow_o  out  1  sticky: an event was dropped
- mod_o  out  4  {caps_lock, alt, ctrl, shift}

## Operation
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (skipping after E1). Transitions occur only on cycles where rx_stb_i=1.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE with skip counter = 7.
  - 00, AA, EE, FA, FE, FF are discarded; stay in IDLE.
  - Any other byte pushes {0,0,byte}; stay in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - 12 or 59 (fake shift) is discarded -> IDLE.
  - Any other byte pushes {1,0,byte} -> IDLE.
- BRK: any byte pushes {0,1,byte} -> IDLE.
- EXT_BRK:
  - 12 or 59 is discarded -> IDLE.
  - Any other byte pushes {1,1,byte} -> IDLE.
- PAUSE: each byte decrements the counter; the byte that takes it to 0 pushes {1,0,0x77} -> IDLE. This is the Pause-key make event; Pause has no break.
- Modifier registers are updated only when the event is pushed, whether or not the FIFO is full:
  - lshift = 12, rshift = 59 (non-ext).
  - lctrl = 14, rctrl = E0 14.
  - lalt = 11, ralt = E0 11.
  - shift = lshift|rshift; ctrl and alt are formed the same way.
  - Make sets the register; break clears it.
- Caps Lock (58, non-ext): caps_lock toggles on a make only while caps_down=0. The make then sets caps_down and the break clears it, so typematic repeats do not toggle.
- FIFO behaviour:
  - Push when full: the event is dropped and overflow_o is set.
  - Push and rd_stb_i in the same cycle while full: both take effect and the count stays full.
  - rd_stb_i while empty is ignored.
  - Pointers wrap modulo depth; the count is FIFO_AW+1 bits wide.
- clr_ovf_i clears overflow_o. If clr_ovf_i coincides with a new overflow, the set wins.

## Timing
- Reset values: state IDLE, FIFO empty, valid_o=0, event_o=0, overflow_o=0, mod_o=0, caps_down=0, skip counter 0.
- rx_stb_i=1 at cycle N updates state, modifiers and the FIFO at the edge ending N. valid_o, event_o and mod_o reflect the change in cycle N+1 (latency 1).
- event_o is registered show-ahead: the head is valid whenever valid_o=1. rd_stb_i at cycle M presents the next entry, or sets valid_o=0, in cycle M+1.
- Back-to-back rx_stb_i on consecutive cycles must be handled: every byte is consumed and none is lost.
- Reset asserted mid-sequence, e.g. after E0 F0, returns to IDLE. The next byte is treated as a fresh code.
- No combinational path from any input to any output.

## Test plan
- Bytes 1C, F0 1C -> two events 0x01C and 0x11C in order, valid_o high from the cycle after the first strobe, mod_o=0 throughout.
- E0 14, 12, E0 F0 14 -> ctrl=1 then shift=1 then ctrl=0, so mod_o 0010 -> 0011 -> 0001. Events pushed: 0x214, 0x012, 0x314.
- 58, 58, F0 58, 58 -> caps_lock 1, 1, 1, 0. E0 12 and E0 F0 12 -> no events pushed.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x277. AA, FA -> no events.
- Push 9 makes (depth 8) with no reads -> 8 events stored and overflow_o=1. In a full-FIFO cycle with simultaneous rd_stb_i and rx_stb_i, the count stays 8 and the order is preserved. clr_ovf_i clears overflow_o.
- Send F0, assert rst_n_i=0 for 1 cycle, then send 1C -> event 0x01C, not a break. All outputs are 0 during reset.
